// File: rtl/wb_mem_slave_if.sv
// Wishbone classic bus bundle between a master (bridge) and the RAM slave.
interface wb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [DATA_WIDTH-1:0] wb_dat_w;
  logic [DATA_WIDTH-1:0] wb_dat_r;
  logic                  wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
    input  wb_dat_r, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
    output wb_dat_r, wb_ack
  );
endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave backed by a word-addressed RAM: latches strobe pulses,
// acks after LATENCY cycles, flags out-of-range accesses, counts busy drops.
module wb_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_mem_slave_if.slave        wb,
  output logic                 oor_flag_o,
  output logic [7:0]           drop_cnt_o
);
  localparam int OFFS  = $clog2(DATA_WIDTH / 8);
  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam int CNT_W = 4;

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("wb_mem_slave: LATENCY must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] dat_r_q;
  logic                  oor_q;
  logic [7:0]            drop_q;
  logic                  we_q, inr_q;
  logic [IDXW-1:0]       idx_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // The extra top bit of the subtraction is the borrow, i.e. adr < BASE_ADDR.
  logic [ADDR_WIDTH:0]   diff;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDXW-1:0]       idx_now;
  logic                  req, in_range, capture, enter_ack;
  logic                  rd_we, rd_inr;
  logic [IDXW-1:0]       rd_idx;

  assign req      = wb.wb_cyc && wb.wb_stb;
  assign diff     = {1'b0, wb.wb_adr} - {1'b0, BASE_ADDR};
  assign word_idx = diff[ADDR_WIDTH-1:0] >> OFFS;
  assign idx_now  = word_idx[IDXW-1:0];
  assign in_range = !diff[ADDR_WIDTH] && ((word_idx >> IDXW) == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        capture = 1'b1;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = (LATENCY > 1) ? WAIT : ACK;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_ack = (state_d == ACK) && (state_q != ACK);

  // With LATENCY=1 the ack edge is also the capture edge, so bypass the latches.
  assign rd_we  = capture ? wb.wb_we  : we_q;
  assign rd_inr = capture ? in_range  : inr_q;
  assign rd_idx = capture ? idx_now   : idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_r_q <= '0;
      oor_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack;
      if (enter_ack && !rd_we) dat_r_q <= rd_inr ? mem[rd_idx] : '0;
      if (capture && !in_range) oor_q <= 1'b1;
      if (req && (state_q != IDLE) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      we_q  <= wb.wb_we;
      inr_q <= in_range;
      idx_q <= idx_now;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && capture && wb.wb_we && in_range) mem[idx_now] <= wb.wb_dat_w;
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_r = dat_r_q;
  assign oor_flag_o  = oor_q;
  assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_wb_mem_slave.sv
// Drives three slaves (LATENCY 2/1/8, two base addresses) from one shared bus and
// checks every cycle against a timeline model of the request/ack protocol.
module tb_wb_mem_slave;
  localparam int          N     = 3;
  localparam int          DEPTH = 1024;
  localparam int          LATS  [N] = '{2, 1, 8};
  localparam logic [31:0] BASES [N] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_1000};

  logic clk = 1'b0;
  logic rst, cyc, stb, we;
  logic [31:0] adr, dat_w;

  logic [N-1:0]       ack_w, oor_w;
  logic [N-1:0][31:0] dat_r_w;
  logic [N-1:0][7:0]  drop_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wb_mem_slave_if bus ();
    assign bus.wb_cyc   = cyc;
    assign bus.wb_stb   = stb;
    assign bus.wb_we    = we;
    assign bus.wb_adr   = adr;
    assign bus.wb_dat_w = dat_w;
    assign ack_w[g]     = bus.wb_ack;
    assign dat_r_w[g]   = bus.wb_dat_r;

    wb_mem_slave #(
      .MEM_DEPTH (DEPTH),
      .BASE_ADDR (BASES[g]),
      .LATENCY   (LATS[g])
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wb         (bus.slave),
      .oor_flag_o (oor_w[g]),
      .drop_cnt_o (drop_w[g])
    );
  end

  // Reference: each slave is busy from its accept edge E until edge E+LAT,
  // and its ack is visible after edge E+LAT-1.
  logic [31:0] mem_m     [N][DEPTH];
  bit          known_m   [N][DEPTH];
  longint      n_edge;
  longint      free_m    [N];
  longint      ack_at    [N];
  bit          pend_we   [N];
  logic [31:0] pend_val  [N];
  bit          pend_known[N];
  bit          exp_ack   [N];
  bit          exp_oor   [N];
  int          exp_drop  [N];
  logic [31:0] exp_dat   [N];
  bit          dat_known [N];
  int          n_cmp, n_bad;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d edge=%0d observed=%h expected=%h", tag, k, n_edge, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] off, wi;
    bit inr;
    int idx;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        free_m[k] = 0; ack_at[k] = -1; exp_ack[k] = 0;
        exp_oor[k] = 0; exp_drop[k] = 0; exp_dat[k] = '0; dat_known[k] = 1;
      end else begin
        exp_ack[k] = 0;
        if (cyc && stb) begin
          if (n_edge >= free_m[k]) begin
            off = adr - BASES[k];
            wi  = off >> 2;
            inr = (adr >= BASES[k]) && (wi < 32'(DEPTH));
            idx = int'(wi[9:0]);
            pend_we[k] = we;
            if (!inr) begin
              exp_oor[k] = 1;
              pend_val[k] = '0; pend_known[k] = 1;
            end else if (we) begin
              mem_m[k][idx] = dat_w; known_m[k][idx] = 1;
            end else begin
              pend_val[k] = mem_m[k][idx]; pend_known[k] = known_m[k][idx];
            end
            ack_at[k] = n_edge + LATS[k] - 1;
            free_m[k] = n_edge + LATS[k] + 1;
          end else if (exp_drop[k] < 255) begin
            exp_drop[k]++;
          end
        end
        if (ack_at[k] == n_edge) begin
          exp_ack[k] = 1;
          if (!pend_we[k]) begin
            exp_dat[k] = pend_val[k]; dat_known[k] = pend_known[k];
          end
          ack_at[k] = -1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk("ack", k, 32'(ack_w[k]), 32'(exp_ack[k]));
      chk("oor_flag", k, 32'(oor_w[k]), 32'(exp_oor[k]));
      chk("drop_cnt", k, 32'(drop_w[k]), 32'(exp_drop[k]));
      if (dat_known[k]) chk("dat_r", k, dat_r_w[k], exp_dat[k]);
    end
  endtask

  task automatic step(input bit c, input bit s, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input bit r);
    cyc = c; stb = s; we = w; adr = a; dat_w = d; rst = r;
    @(posedge clk);
    n_edge++;
    model_edge();
    #1;
    check_all();
  endtask

  // Idle cycles carry garbage on everything but cyc, which must be ignored.
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, a, $urandom, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    n_cmp = 0; n_bad = 0; n_edge = 0;
    for (int k = 0; k < N; k++) begin
      free_m[k] = 0; ack_at[k] = -1; dat_known[k] = 0;
      exp_ack[k] = 0; exp_oor[k] = 0; exp_drop[k] = 0; exp_dat[k] = '0;
    end

    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(2);

    wr(32'h10, 32'hDEAD_BEEF); idle(9);
    rd(32'h10);                idle(9);

    wr(32'h1000, 32'h1111_2222); idle(9);
    wr(32'h2000, 32'h5555_AAAA); idle(9);
    rd(32'h1000);                idle(9);
    rd(32'h0FFC);                idle(9);

    wr(32'h1004, 32'hA0A0_0001);
    wr(32'h1008, 32'hB0B0_0002);
    wr(32'h100C, 32'hC0C0_0003);
    idle(10);
    rd(32'h1004); idle(9);
    rd(32'h1008); idle(9);
    rd(32'h100C); idle(9);

    for (int i = 0; i < 600; i++) rd(32'h1004);
    idle(10);

    rd(32'h1004);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(10);
    rd(32'h10);   idle(9);
    rd(32'h1004); idle(9);

    a = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        a = ($urandom_range(0, 1) == 1) ? 32'h1000 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3)
                                        : 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
        wr(a, $urandom);
      end else begin
        rd(a);
      end
      idle(9);
    end

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           32'h0F00 + $urandom_range(0, 32'h1400), $urandom, 1'($urandom_range(0, 99) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Wishbone classic slave that terminates the Wishbone side of the AHB-to-Wishbone bridge with a word-addressed on-chip RAM. It latches single-cycle strobe pulses, as the bridge produces them, then returns one `wb_ack` pulse after a programmable number of wait cycles. It also flags out-of-range accesses and counts strobes that arrive while a request is still pending.

## Interface
- `ADDR_WIDTH`, 32, byte-address width
- `DATA_WIDTH`, 32, data width; one word = DATA_WIDTH/8 bytes
- `MEM_DEPTH`, 1024, RAM words (power of two)
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0
- `LATENCY`, 2, cycles from strobe sample to ack; legal 1..8
- `clk  in  1`  clock; all logic on rising edge
- `rst  in  1`  reset, synchronous, active-high
- `wb_cyc  in  1`  cycle valid
- `wb_stb  in  1`  strobe; request is `wb_cyc && wb_stb`
- `wb_we  in  1`  1 = write
- `wb_adr  in  ADDR_WIDTH`  byte address
- `wb_dat_w  in  DATA_WIDTH`  write data
- `wb_dat_r  out  DATA_WIDTH`  read data
- `wb_ack  out  1`  one-cycle acknowledge
- `oor_flag  out  1`  sticky: an out-of-range request was seen
- `drop_cnt  out  8`  saturating count of requests ignored while busy

## Operation
- FSM states: IDLE, WAIT, ACK. Reset forces IDLE. Reset also forces `wb_ack`=0, `wb_dat_r`=0, `oor_flag`=0, `drop_cnt`=0 and wait counter=0. RAM contents are not reset.
- **IDLE:**
  - A request at a sampling edge is captured: `wb_we`, word index, data and range result.
  - Next state is WAIT if LATENCY>1, else ACK.
  - The counter loads LATENCY-1.
- **Offset and word index:**
  - offset = `wb_adr - BASE_ADDR`, ADDR_WIDTH bits, modulo arithmetic.
  - word index = offset >> log2(DATA_WIDTH/8). Low offset bits are ignored, so there are no byte lanes.
- **Range check:** in range iff `wb_adr >= BASE_ADDR` and word index < MEM_DEPTH.
- **Out of range:**
  - The write is discarded.
  - A read returns 0.
  - `oor_flag` sets at the capture edge and stays 1 until reset.
  - The request is still acknowledged normally.
- **Writes:** the RAM is written at the capture edge with captured data. `wb_dat_r` is unchanged by writes.
- **Reads:**
  - RAM is read from the captured index.
  - `wb_dat_r` is loaded at the edge that raises `wb_ack`.
  - `wb_dat_r` holds its value until the next read ack.
- **WAIT:** the counter decrements each cycle. When it reaches 1, next state is ACK.
- **ACK:**
  - `wb_ack`=1 for exactly this one cycle, then return to IDLE.
  - A request sampled during the ACK cycle is not accepted.
- **Busy drops:**
  - Any request sampled in WAIT or ACK is ignored. It causes no RAM write and no flag change.
  - Each such request increments `drop_cnt`, saturating at 255.
- **`wb_cyc` low:** deasserting `wb_cyc` after capture does not abort the request; the ack still issues.
- **Mid-operation reset:** the pending request is abandoned and no ack issues. A write captured before reset stays committed.

## Timing
- Request sampled at edge E. `wb_ack` is high during the cycle after edge E+LATENCY-1, i.e. it is registered at edge E+LATENCY-1.
- LATENCY=1 gives ack in the cycle directly after the strobe cycle.
- Throughput: the next request is accepted no earlier than the edge after the ack cycle. Back-to-back requests are spaced at LATENCY+1 cycles.
- `wb_dat_r` is valid in the ack cycle; `wb_ack` is never high for two consecutive cycles.
- Write visibility: a read captured at the edge after a write's capture edge returns the new data.
- LATENCY outside 1..8 is an elaboration error (`$error`).

## Test plan
- **Write/read, LATENCY=2:**
  - Write 0xDEADBEEF to 0x10; ack comes 2 cycles after the strobe.
  - Read 0x10: ack after 2 cycles with `wb_dat_r`=0xDEADBEEF, ack high exactly 1 cycle.
- **Latency sweep, LATENCY=1 and 8:** single read; ack arrives at +1 and +8 cycles respectively, each lasting 1 cycle.
- **Out of range, MEM_DEPTH=1024, BASE_ADDR=0x1000:**
  - Write 0x5555AAAA to 0x2000 (word 1024): acked, `oor_flag`=1, RAM word 0 unchanged.
  - Read 0x0FFC: returns 0.
- **Busy drops:**
  - Pulse a request at capture+1 and capture+2 while in WAIT: `drop_cnt`=2, only the first request is acked, no RAM change.
  - Issue 300 dropped strobes: `drop_cnt`=255.
- **Mid-operation reset:**
  - Assert `rst` one cycle before an expected read ack: no ack.
  - All outputs are 0 the cycle after reset.
  - A new read of a previously written word returns the stored value.
- **Bridge-style traffic:** 1-cycle `wb_cyc`/`wb_stb` pulses with `wb_cyc` dropped immediately; ack still issues with correct data for 16 alternating write/read addresses.
